// File: rtl/mem_strobe_pkg.sv
// Shared types for the start/write/addr/data strobe memory initiator.
// Optional statistics counters are enabled by defining MEM_STROBE_STATS_EN.
package mem_strobe_pkg;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} strobe_state_e;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_cmd_t;

  // Phase counter width: enough bits for the longest phase, never below 1.
  function automatic int unsigned cnt_width(input int unsigned s, input int unsigned t,
                                            input int unsigned h);
    int unsigned m;
    m = s;
    if (t > m) m = t;
    if (h > m) m = h;
    return (m > 1) ? int'($clog2(m)) : 1;
  endfunction

endpackage

// File: rtl/mem_cmd_fifo.sv
// Command FIFO for the strobe initiator; registered full/empty flags.
// Full reads 1 during reset so the command port accepts nothing until released.
module mem_cmd_fifo
  import mem_strobe_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  mem_cmd_t push_cmd,
  input  logic     pop,
  output mem_cmd_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  mem_cmd_t          mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic              do_push;
  logic              do_pop;

  // A pop never frees space for a push in the same cycle: full gates push.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b1;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_cmd;
  end

endmodule

// File: rtl/mem_strobe_initiator.sv
// Race-free strobe initiator: addr/data/write settle SETUP_CYC cycles before start rises.
// Define MEM_STROBE_STATS_EN to add saturating wr_count/rd_count outputs.
module mem_strobe_initiator #(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 1,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          start,
  output logic          write,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          busy,
  output logic          done
`ifdef MEM_STROBE_STATS_EN
  ,
  output logic [15:0]   wr_count,
  output logic [15:0]   rd_count
`endif
);

  import mem_strobe_pkg::*;

  localparam int unsigned CNT_W = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam int unsigned CAW   = mem_strobe_pkg::AW;
  localparam int unsigned CDW   = mem_strobe_pkg::DW;

  strobe_state_e    state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  mem_cmd_t         push_cmd;
  mem_cmd_t         head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign push_cmd  = '{write: cmd_write, addr: CAW'(cmd_addr), data: CDW'(cmd_data)};
  assign cnt_zero  = (cnt == '0);
  // Head is taken from IDLE or from the last HOLD cycle (back-to-back issue).
  assign pop       = !fifo_empty && ((state == IDLE) || ((state == HOLD) && cnt_zero));
  assign busy      = (state != IDLE) || !fifo_empty;

  mem_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_cmd (push_cmd),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      start <= 1'b0;
      write <= 1'b0;
      addr  <= '0;
      data  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        SETUP: begin
          if (cnt_zero) begin
            state <= STROBE;
            start <= 1'b1;
            cnt   <= CNT_W'(STROBE_CYC - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        STROBE: begin
          if (cnt_zero) begin
            state <= HOLD;
            start <= 1'b0;
            write <= 1'b0;
            cnt   <= CNT_W'(HOLD_CYC - 1);
            done  <= (HOLD_CYC == 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt_zero) begin
            state <= IDLE;
          end else begin
            cnt  <= cnt - CNT_W'(1);
            done <= (cnt == CNT_W'(1));
          end
        end
        default: ;
      endcase
      // New command overrides the HOLD->IDLE exit; values change only while start is low.
      if (pop) begin
        state <= SETUP;
        cnt   <= CNT_W'(SETUP_CYC - 1);
        write <= head.write;
        addr  <= AW'(head.addr);
        data  <= DW'(head.data);
      end
    end
  end

`ifdef MEM_STROBE_STATS_EN
  // Counted on the edge where start rises, using the latched write qualifier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
      rd_count <= '0;
    end else if ((state == SETUP) && cnt_zero) begin
      if (write) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_strobe_initiator.sv
// Directed self-checking bench for mem_strobe_initiator (default and 2/3/2 timing instances).
// Stats checks are compiled in when MEM_STROBE_STATS_EN is defined.
module tb_mem_strobe_initiator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       cmd_valid, cmd_write, cmd_ready;
  logic [7:0] cmd_addr, cmd_data;
  logic       start, write, busy, done;
  logic [7:0] addr, data;

  logic       s_valid, s_write, s_ready;
  logic [7:0] s_addr, s_data;
  logic       s_start, s_wr, s_busy, s_done;
  logic [7:0] s_ad, s_da;

`ifdef MEM_STROBE_STATS_EN
  logic [15:0] wr_count, rd_count, s_wrc, s_rdc;
`endif

  int pass_cnt = 0;
  int tot_cnt  = 0;

  mem_strobe_initiator u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .start(start), .write(write), .addr(addr), .data(data), .busy(busy), .done(done)
`ifdef MEM_STROBE_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count)
`endif
  );

  mem_strobe_initiator #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) u_slow (
    .clk(clk), .rst(rst), .cmd_valid(s_valid), .cmd_ready(s_ready),
    .cmd_write(s_write), .cmd_addr(s_addr), .cmd_data(s_data),
    .start(s_start), .write(s_wr), .addr(s_ad), .data(s_da), .busy(s_busy), .done(s_done)
`ifdef MEM_STROBE_STATS_EN
    , .wr_count(s_wrc), .rd_count(s_rdc)
`endif
  );

  // Memory model and strobe monitor for the default instance.
  int          cyc = 0;
  logic        prev_start = 1'b0;
  logic        prev_write = 1'b0;
  logic [7:0]  prev_addr = '0, prev_data = '0;
  int          stab_viol = 0;
  int          done_cnt = 0;
  logic [16:0] issue_q [$];
  int          rise_q [$];
  logic [7:0]  mem [256];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (start && !prev_start) begin
      if ({write, addr, data} !== {prev_write, prev_addr, prev_data}) stab_viol++;
      issue_q.push_back({write, addr, data});
      rise_q.push_back(cyc);
      if (write) mem[addr] = data;
    end
    if (done) done_cnt++;
    prev_start = start;
    prev_write = write;
    prev_addr  = addr;
    prev_data  = data;
  end

  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d);
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_data = 0;
    s_valid = 0; s_write = 0; s_addr = 0; s_data = 0;
    repeat (3) @(negedge clk);
    tot_cnt++;
    if ({start, write, done, busy, cmd_ready} !== 5'b0)
      $display("FAIL reset_ctrl: got %b expected 00000", {start, write, done, busy, cmd_ready});
    else pass_cnt++;
    tot_cnt++;
    if ({addr, data} !== 16'h0) $display("FAIL reset_bus: got %h expected 0000", {addr, data});
    else pass_cnt++;
    tot_cnt++;
    if ({s_start, s_busy, s_ready, s_done} !== 4'b0)
      $display("FAIL reset_slow: got %b expected 0000", {s_start, s_busy, s_ready, s_done});
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    tot_cnt++;
    if ({cmd_ready, s_ready} !== 2'b11) $display("FAIL reset_ready: got %b expected 11", {cmd_ready, s_ready});
    else pass_cnt++;
  endtask

  task automatic test_single_write;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h42; cmd_data = 8'h5a;
    @(negedge clk);
    cmd_valid = 0;
    tot_cnt++;
    if ({start, busy} !== 2'b01) $display("FAIL single_queued: got %b expected 01", {start, busy});
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if ({start, write, addr, data} !== {2'b01, 16'h425a})
      $display("FAIL single_setup: got %h expected %h", {start, write, addr, data}, {2'b01, 16'h425a});
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if ({start, write} !== 2'b11) $display("FAIL single_strobe: got %b expected 11", {start, write});
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if ({start, write, done, addr, data} !== {3'b001, 16'h425a})
      $display("FAIL single_hold: got %h expected %h", {start, write, done, addr, data}, {3'b001, 16'h425a});
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if ({done, busy, start} !== 3'b0) $display("FAIL single_idle: got %b expected 000", {done, busy, start});
    else pass_cnt++;
    tot_cnt++;
    if (mem[8'h42] !== 8'h5a) $display("FAIL single_mem: got %h expected 5a", mem[8'h42]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int base, d0, gap;
    base = rise_q.size();
    d0   = done_cnt;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h42; cmd_data = 8'h5a;
    @(negedge clk);
    cmd_addr = 8'h22; cmd_data = 8'haa;
    @(negedge clk);
    cmd_valid = 0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    tot_cnt++;
    if (busy !== 1'b0) $display("FAIL b2b_drain: busy got %b expected 0", busy);
    else pass_cnt++;
    tot_cnt++;
    if (rise_q.size() - base !== 2) $display("FAIL b2b_strobes: got %0d expected 2", rise_q.size() - base);
    else pass_cnt++;
    gap = (rise_q.size() >= base + 2) ? rise_q[base+1] - rise_q[base] : -1;
    tot_cnt++;
    if (gap !== 3) $display("FAIL b2b_gap: got %0d expected 3", gap);
    else pass_cnt++;
    tot_cnt++;
    if (mem[8'h22] !== 8'haa) $display("FAIL b2b_mem: got %h expected aa", mem[8'h22]);
    else pass_cnt++;
    tot_cnt++;
    if (done_cnt - d0 !== 2) $display("FAIL b2b_done: got %0d expected 2", done_cnt - d0);
    else pass_cnt++;
    tot_cnt++;
    if (stab_viol !== 0) $display("FAIL b2b_stable: violations got %0d expected 0", stab_viol);
    else pass_cnt++;
  endtask

  task automatic test_full_fifo;
    int base, idx, first_stall, bad, bad_i;
    logic rdy_prev;
    logic [16:0] exp, got;
    logic [7:0] a, d;
    base = issue_q.size();
    idx = 0; first_stall = -1; rdy_prev = 0; bad = 0; bad_i = -1; got = '0; exp = '0;
    cmd_valid = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (cmd_valid && rdy_prev) idx++;
      if (idx < 7) begin
        a = 8'(96 + idx); d = 8'(192 + idx);
        cmd_valid = 1; cmd_write = (idx % 2 == 0); cmd_addr = a; cmd_data = d;
      end else begin
        cmd_valid = 0;
      end
      if (cmd_valid && !cmd_ready && first_stall < 0) first_stall = idx;
      rdy_prev = cmd_ready;
      if (idx == 7 && !busy) break;
    end
    cmd_valid = 0;
    tot_cnt++;
    if (first_stall !== 6) $display("FAIL full_stall: accepted before stall got %0d expected 6", first_stall);
    else pass_cnt++;
    tot_cnt++;
    if (idx !== 7 || busy !== 1'b0) $display("FAIL full_accept: got %0d/busy %b expected 7/0", idx, busy);
    else pass_cnt++;
    tot_cnt++;
    if (issue_q.size() - base !== 7) $display("FAIL full_issued: got %0d expected 7", issue_q.size() - base);
    else pass_cnt++;
    for (int i = 0; i < 7; i++) begin
      exp = {(i % 2 == 0) ? 1'b1 : 1'b0, 8'(96 + i), 8'(192 + i)};
      if (base + i >= issue_q.size() || issue_q[base+i] !== exp) begin
        bad++;
        if (bad_i < 0) begin
          bad_i = i;
          got = (base + i < issue_q.size()) ? issue_q[base+i] : 'x;
        end
      end
    end
    tot_cnt++;
    if (bad !== 0) $display("FAIL full_order: entry %0d got %h expected %h", bad_i, got,
                            {(bad_i % 2 == 0) ? 1'b1 : 1'b0, 8'(96 + bad_i), 8'(192 + bad_i)});
    else pass_cnt++;
    tot_cnt++;
    if (stab_viol !== 0) $display("FAIL full_stable: violations got %0d expected 0", stab_viol);
    else pass_cnt++;
  endtask

  task automatic test_timing;
    int first_addr, first_start, hi, done_at, done_n;
    first_addr = -1; first_start = -1; hi = 0; done_at = -1; done_n = 0;
    s_valid = 1; s_write = 1; s_addr = 8'h10; s_data = 8'hff;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) s_valid = 0;
      if (s_ad == 8'h10 && first_addr < 0) first_addr = k;
      if (s_start) begin
        hi++;
        if (first_start < 0) first_start = k;
        if ({s_wr, s_ad, s_da} !== 17'h110ff) hi += 100;
      end
      if (s_done) begin done_n++; done_at = k; end
    end
    tot_cnt++;
    if (first_addr !== 2) $display("FAIL timing_addr: got %0d expected 2", first_addr);
    else pass_cnt++;
    tot_cnt++;
    if (first_start - first_addr !== 2) $display("FAIL timing_setup: got %0d expected 2", first_start - first_addr);
    else pass_cnt++;
    tot_cnt++;
    if (hi !== 3) $display("FAIL timing_strobe: got %0d expected 3", hi);
    else pass_cnt++;
    tot_cnt++;
    if (done_at - first_addr + 1 !== 7) $display("FAIL timing_done_cycle: got %0d expected 7", done_at - first_addr + 1);
    else pass_cnt++;
    tot_cnt++;
    if (done_n !== 1) $display("FAIL timing_done_count: got %0d expected 1", done_n);
    else pass_cnt++;
    tot_cnt++;
    if (s_busy !== 1'b0) $display("FAIL timing_idle: busy got %b expected 0", s_busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_strobe;
    int base, d0, hi;
    base = rise_q.size(); d0 = done_cnt; hi = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h30; cmd_data = 8'h11;
    @(negedge clk);
    cmd_addr = 8'h31; cmd_data = 8'h12;
    @(negedge clk);
    cmd_addr = 8'h32; cmd_data = 8'h13;
    @(negedge clk);
    cmd_valid = 0;
    tot_cnt++;
    if (start !== 1'b1) $display("FAIL rst_pre_strobe: start got %b expected 1", start);
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    tot_cnt++;
    if ({start, busy, done, cmd_ready} !== 4'b0)
      $display("FAIL rst_async: got %b expected 0000", {start, busy, done, cmd_ready});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (start) hi++;
    end
    tot_cnt++;
    if (rise_q.size() - base !== 1 || hi !== 0)
      $display("FAIL rst_no_strobe: strobes got %0d/%0d expected 1/0", rise_q.size() - base, hi);
    else pass_cnt++;
    tot_cnt++;
    if (done_cnt !== d0) $display("FAIL rst_no_done: got %0d expected %0d", done_cnt - d0, 0);
    else pass_cnt++;
    tot_cnt++;
    if ({busy, cmd_ready} !== 2'b01) $display("FAIL rst_idle: got %b expected 01", {busy, cmd_ready});
    else pass_cnt++;
  endtask

`ifdef MEM_STROBE_STATS_EN
  task automatic test_stats;
    tot_cnt++;
    if ({wr_count, rd_count} !== 32'h0) $display("FAIL stats_reset: got %h expected 0", {wr_count, rd_count});
    else pass_cnt++;
    send(1, 8'h01, 8'h10);
    send(0, 8'h02, 8'h20);
    send(1, 8'h03, 8'h30);
    send(0, 8'h04, 8'h40);
    send(1, 8'h05, 8'h50);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    tot_cnt++;
    if (wr_count !== 16'd3) $display("FAIL stats_wr: got %0d expected 3", wr_count);
    else pass_cnt++;
    tot_cnt++;
    if (rd_count !== 16'd2) $display("FAIL stats_rd: got %0d expected 2", rd_count);
    else pass_cnt++;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_full_fifo();
    test_timing();
    test_reset_mid_strobe();
`ifdef MEM_STROBE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
